// File: rtl/nightlight_ctrl.sv
// Nightlight sequencing controller: drives a six-digit BCD countdown timer
// (load / 1-second enable), watches its digits for warning and expiry, and drives the lamp.
module nightlight_ctrl #(
   parameter int TICK_DIV = 4,
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       dark,
   input  logic       btn,
   input  logic [3:0] x5,
   input  logic [3:0] x4,
   input  logic [3:0] x3,
   input  logic [3:0] x2,
   input  logic [3:0] x1,
   input  logic [3:0] x0,
   output logic       tmr_set,
   output logic       tmr_tick,
   output logic       light,
   output logic       expired,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_OFF  = 2'd0,
      S_ON   = 2'd1,
      S_WARN = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam int             PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [7:0]     DEB_FULL  = 8'(DEBOUNCE);
   localparam logic [7:0]     DEB_LAST  = 8'(DEBOUNCE - 1);

   // Saturates at DEBOUNCE so a long hold never produces a second press.
   function automatic logic [7:0] deb_sat_inc(input logic [7:0] v);
      return (v == DEB_FULL) ? v : v + 8'd1;
   endfunction

   state_t        state_q;
   state_t        state_d;
   logic          dark_q;
   logic [7:0]    deb_cnt;
   logic [PW-1:0] presc;
   logic          set_q;

   logic press;
   logic dark_rise;
   logic digits_stale;
   logic warn_zone;
   logic all_zero;
   logic run;
   logic tick_raw;
   logic set_d;
   logic tick_d;
   logic light_d;
   logic expired_d;

   // ---- input conditioning ----
   assign press     = btn && (deb_cnt == DEB_LAST);
   assign dark_rise = dark && !dark_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dark_q  <= 1'b0;
         deb_cnt <= 8'd0;
      end else begin
         dark_q  <= dark;
         deb_cnt <= btn ? deb_sat_inc(deb_cnt) : 8'd0;
      end
   end

   // ---- zero detection; digits lag a load by up to two cycles ----
   assign digits_stale = tmr_set || set_q;
   assign warn_zone    = !digits_stale && ({x5, x4, x3, x2, x1} == 20'd0);
   assign all_zero     = warn_zone && (x0 == 4'd0);

   // ---- prescaler ----
   assign run      = (state_q == S_ON) || (state_q == S_WARN);
   assign tick_raw = run && (presc == PRESC_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (set_d) begin
         presc <= '0;
      end else if (run) begin
         presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end
   end

   // ---- state machine: next state and registered-output values ----
   always_comb begin
      state_d   = state_q;
      set_d     = 1'b0;
      expired_d = 1'b0;
      light_d   = light;
      case (state_q)
         S_OFF: begin
            light_d = 1'b0;
            if (press || dark_rise) begin
               state_d = S_ON;
               set_d   = 1'b1;
               light_d = 1'b1;
            end
         end
         S_ON: begin
            light_d = 1'b1;
            if (press) begin
               state_d = S_OFF;
               light_d = 1'b0;
            end else if (warn_zone) begin
               state_d = S_WARN;
            end
         end
         S_WARN: begin
            if (press) begin
               state_d = S_ON;
               set_d   = 1'b1;
               light_d = 1'b1;
            end else if (all_zero) begin
               state_d   = S_HOLD;
               expired_d = 1'b1;
               light_d   = 1'b0;
            end else begin
               light_d = light ^ tick_raw;
            end
         end
         S_HOLD: begin
            light_d = 1'b0;
            if (press) begin
               state_d = S_ON;
               set_d   = 1'b1;
               light_d = 1'b1;
            end else if (!dark) begin
               state_d = S_OFF;
            end
         end
         default: begin
            state_d = S_OFF;
            light_d = 1'b0;
         end
      endcase
   end

   // A tick is dropped when the timer is being loaded or the count is stopping.
   assign tick_d = tick_raw && !set_d && ((state_d == S_ON) || (state_d == S_WARN));

   // ---- output registers ----
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_OFF;
         tmr_set  <= 1'b0;
         tmr_tick <= 1'b0;
         light    <= 1'b0;
         expired  <= 1'b0;
         set_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_set  <= set_d;
         tmr_tick <= tick_d;
         light    <= light_d;
         expired  <= expired_d;
         set_q    <= tmr_set;
      end
   end

   assign state = state_q;

   a_set_single: assert property (@(posedge clk) disable iff (rst) tmr_set |=> !tmr_set);
   a_tick_legal: assert property (@(posedge clk) disable iff (rst)
      tmr_tick |-> (!tmr_set && ((state_q == S_ON) || (state_q == S_WARN))));

endmodule

// File: tb/tb_nightlight_ctrl.sv
// Directed bench for nightlight_ctrl: stimulus pushes per-cycle expectations into a
// scoreboard queue; a negedge monitor pops and compares them against the outputs.
module tb_nightlight_ctrl;

   localparam logic [1:0] OFF  = 2'd0;
   localparam logic [1:0] ON   = 2'd1;
   localparam logic [1:0] WARN = 2'd2;
   localparam logic [1:0] HOLD = 2'd3;

   typedef struct {
      int         cyc;
      logic [1:0] st;
      logic       l;
      logic       s;
      logic       t;
      logic       e;
      string      name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dark;
   logic        btn;
   logic [23:0] dig;
   logic [3:0]  x5, x4, x3, x2, x1, x0;
   logic        tmr_set, tmr_tick, light, expired;
   logic [1:0]  state;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   logic done  = 1'b0;
   exp_t sb[$];
   exp_t it;

   assign {x5, x4, x3, x2, x1, x0} = dig;

   nightlight_ctrl #(.TICK_DIV(4), .DEBOUNCE(3)) dut (
      .clk(clk), .rst(rst), .dark(dark), .btn(btn),
      .x5(x5), .x4(x4), .x3(x3), .x2(x2), .x1(x1), .x0(x0),
      .tmr_set(tmr_set), .tmr_tick(tmr_tick), .light(light),
      .expired(expired), .state(state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && (sb[0].cyc <= cyc || done)) begin
         it = sb.pop_front();
         total++;
         if (it.cyc != cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d never compared (now cycle %0d)",
                     it.name, it.cyc, cyc);
         end else if ({state, light, tmr_set, tmr_tick, expired} !==
                      {it.st, it.l, it.s, it.t, it.e}) begin
            bad++;
            $display("FAIL %s @cycle %0d: got st=%0d light=%b set=%b tick=%b exp=%b, want st=%0d light=%b set=%b tick=%b exp=%b",
                     it.name, cyc, state, light, tmr_set, tmr_tick, expired,
                     it.st, it.l, it.s, it.t, it.e);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expect the given outputs after the next clock edge, then advance to it.
   task automatic ex(input logic [1:0] st, input logic l, input logic s,
                     input logic t, input logic e, input string nm);
      exp_t x;
      x.cyc = cyc + 1;
      x.st = st; x.l = l; x.s = s; x.t = t; x.e = e; x.name = nm;
      sb.push_back(x);
      step();
   endtask

   initial begin
      rst = 1'b1; dark = 1'b1; btn = 1'b0; dig = 24'h595959;
      ex(OFF, 0, 0, 0, 0, "reset_a");
      ex(OFF, 0, 0, 0, 0, "reset_b");

      // release reset with dark already high: rising edge seen immediately
      rst = 1'b0;
      ex(ON, 1, 1, 0, 0, "trigger_set");
      for (int r = 1; r <= 20; r++)
         ex(ON, 1, 0, (r % 4 == 0), 0, "presc_tick");

      // warning window: light toggles with each tick
      dig = 24'h000009;
      ex(WARN, 1, 0, 0, 0, "warn_enter");
      ex(WARN, 1, 0, 0, 0, "warn_hold_a");
      ex(WARN, 1, 0, 0, 0, "warn_hold_b");
      ex(WARN, 0, 0, 1, 0, "warn_toggle_off");
      ex(WARN, 0, 0, 0, 0, "warn_dim_a");
      ex(WARN, 0, 0, 0, 0, "warn_dim_b");
      ex(WARN, 0, 0, 0, 0, "warn_dim_c");
      ex(WARN, 1, 0, 1, 0, "warn_toggle_on");
      ex(WARN, 1, 0, 0, 0, "warn_lit");

      dig = 24'h000000;
      ex(HOLD, 0, 0, 0, 1, "expire");
      ex(HOLD, 0, 0, 0, 0, "expire_one_cycle");
      dark = 1'b0; dig = 24'h595959;
      ex(OFF, 0, 0, 0, 0, "hold_to_off");

      // two-sample button blip is not a press
      btn = 1'b1;
      ex(OFF, 0, 0, 0, 0, "blip_a");
      ex(OFF, 0, 0, 0, 0, "blip_b");
      btn = 1'b0;
      ex(OFF, 0, 0, 0, 0, "blip_no_press");
      ex(OFF, 0, 0, 0, 0, "blip_idle");

      dark = 1'b1;
      ex(ON, 1, 1, 0, 0, "rise_on");
      // ten-cycle hold gives one press on its third sample
      btn = 1'b1;
      ex(ON, 1, 0, 0, 0, "deb_1");
      ex(ON, 1, 0, 0, 0, "deb_2");
      ex(OFF, 0, 0, 0, 0, "manual_off");
      for (int i = 0; i < 7; i++)
         ex(OFF, 0, 0, 0, 0, "single_press");
      btn = 1'b0;
      ex(OFF, 0, 0, 0, 0, "btn_released");

      // press from OFF; digits stale for two cycles after the load
      btn = 1'b1;
      ex(OFF, 0, 0, 0, 0, "press_a");
      ex(OFF, 0, 0, 0, 0, "press_b");
      ex(ON, 1, 1, 0, 0, "press_on");
      btn = 1'b0; dig = 24'h000005;
      ex(ON, 1, 0, 0, 0, "stale_set_cycle");
      ex(ON, 1, 0, 0, 0, "stale_after_set");
      ex(WARN, 1, 0, 0, 0, "warn_after_stale");
      ex(WARN, 0, 0, 1, 0, "warn2_tick");

      // press lands on the same edge that first sees all-zero
      btn = 1'b1;
      ex(WARN, 0, 0, 0, 0, "ext_a");
      ex(WARN, 0, 0, 0, 0, "ext_b");
      dig = 24'h000000;
      ex(ON, 1, 1, 0, 0, "extend_wins");
      btn = 1'b0; dig = 24'h595959;
      ex(ON, 1, 0, 0, 0, "no_expire");
      ex(ON, 1, 0, 0, 0, "extend_on");

      // expiry on a tick edge: tick suppressed into HOLD
      dig = 24'h000009;
      ex(WARN, 1, 0, 0, 0, "warn3");
      dig = 24'h000000;
      ex(HOLD, 0, 0, 0, 1, "expire_no_tick");
      dig = 24'h595959;
      ex(HOLD, 0, 0, 0, 0, "hold_dark_a");

      // rearm from HOLD by button while dark stays high
      btn = 1'b1;
      ex(HOLD, 0, 0, 0, 0, "hold_dark_b");
      ex(HOLD, 0, 0, 0, 0, "hold_dark_c");
      ex(ON, 1, 1, 0, 0, "rearm");
      btn = 1'b0; dig = 24'h000009;
      ex(ON, 1, 0, 0, 0, "rearm_stale_a");
      ex(ON, 1, 0, 0, 0, "rearm_stale_b");
      ex(WARN, 1, 0, 0, 0, "warn4");

      // reset in WARN on the edge a tick was due
      rst = 1'b1;
      ex(OFF, 0, 0, 0, 0, "mid_reset");
      rst = 1'b0; dig = 24'h595959;
      ex(ON, 1, 1, 0, 0, "post_reset_rise");
      dark = 1'b0;
      ex(ON, 1, 0, 0, 0, "post_reset_on");

      for (int i = 0; i < 5 && sb.size() > 0; i++) step();
      done = 1'b1;
      step();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nightlight_ctrl.md
Name: nightlight_ctrl

Overview:
Sequencing controller for the nightlight's six-digit BCD countdown timer (HH:MM:SS, reloads to 59:59:59 on set).
- Decides when the timer loads and when it counts, via a 1-second enable prescaler.
- Watches the timer digits to detect the warning window and expiry.
- Drives the lamp from the ambient dark sensor and a debounced push-button.

Parameters:
TICK_DIV, 4, clk cycles per timer second; legal range 2..2^16.
DEBOUNCE, 3, consecutive high samples of btn required to register one press; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous reset, active-high.
dark  input  1  ambient sensor, already synchronous to clk; 1 = dark.
btn  input  1  raw push-button level, synchronous to clk.
x5..x0  input  4 each  timer BCD digits: x5 = hour tens, x0 = second ones.
tmr_set  output  1  one-cycle load pulse to the timer.
tmr_tick  output  1  one-cycle count enable; the timer decrements one second per cycle with tmr_tick=1.
light  output  1  lamp drive.
expired  output  1  one-cycle pulse when the countdown reaches zero.
state  output  2  current state: 0 OFF, 1 ON, 2 WARN, 3 HOLD.

Behaviour:
- Reset: state=OFF; light, tmr_set, tmr_tick and expired = 0; prescaler, debounce counter and dark_q = 0. rst mid-operation aborts any state in the same edge.
- All outputs are registered.

Input conditioning:
- press: one-cycle internal pulse, raised in the cycle where btn has been sampled high exactly DEBOUNCE consecutive times.
- Exactly one press per btn high period. The debounce counter clears whenever btn=0.
- dark_rise: dark=1 while dark_q=0 (dark_q is dark registered one cycle).

Zero detection:
- warn_zone = x5..x1 all 0, i.e. fewer than 10 s left.
- all_zero = x5..x0 all 0.
- Both are ignored in the cycle tmr_set=1 and in the cycle after it, because the digits are stale then.

Prescaler:
- Counts 0..TICK_DIV-1 only in ON and WARN. It is cleared to 0 whenever tmr_set is issued.
- tmr_tick=1 for the cycle after the count equals TICK_DIV-1; the count then wraps to 0.
- First tick comes TICK_DIV cycles after tmr_set.

State machine (transitions evaluated at posedge):
- OFF: light=0, no ticks.
  - dark_rise or press -> ON with tmr_set=1 next cycle.
  - Both in the same cycle -> a single ON entry with one tmr_set pulse.
- ON: light=1.
  - press -> OFF (manual off).
  - Otherwise warn_zone -> WARN.
- WARN: light toggles on each tmr_tick cycle and enters WARN with light=1.
  - press -> ON with tmr_set=1 (extend).
  - Otherwise all_zero -> HOLD with expired=1 for one cycle.
  - press wins over a simultaneous all_zero: no expired pulse.
- HOLD: light=0, no ticks.
  - press -> ON with tmr_set=1.
  - Otherwise dark=0 -> OFF.
  - While dark stays 1, HOLD persists, so no retrigger occurs without a new dark edge.
- tmr_set is never high for two consecutive cycles. tmr_tick is never high in OFF or HOLD, nor in the same cycle as tmr_set.

Test Plan:
- Reset and trigger: rst=1 for 2 cycles with dark=1 -> all outputs 0, state=0. Release rst, hold dark=1 -> dark_rise at the first edge, tmr_set=1 for exactly one cycle, state=1, light=1.
- Prescaler: TICK_DIV=4, in ON for 20 cycles -> tmr_tick pulses at cycles 4, 8, 12, 16, 20 after tmr_set, each 1 cycle wide.
- Warning and expiry: bench drives digits 00:00:09 -> state=2, light toggles on each tick. Then drive 00:00:00 -> expired=1 for one cycle, state=3, light=0. Drop dark -> state=0.
- Debounce: DEBOUNCE=3, btn high 2 cycles then low -> no press, state unchanged. btn high 10 cycles in ON -> exactly one press, state=0.
- Extend vs. expire: in WARN, drive all_zero in the same cycle the press pulse fires -> state=1, tmr_set pulse, no expired pulse.
- Rearm and mid-operation reset: in HOLD with dark=1, press -> ON with tmr_set. Assert rst while in WARN -> next cycle state=0, light=0, tmr_tick=0.
